gradient_batch_arbiter: RTL

Shares one gradient adder input stream between `NUM_SRC` TCP receive streams, granting one whole gradient batch at a time in round-robin order. Sits between the per-session receive FIFOs and the packet-state/adder datapath. It parses the header beat of each batch: N in `TDATA[31:0]`, batch length of ceil((N+1)/16) 512-bit lines including the header. It holds the grant until the last line has transferred, so batches from different sources never interleave.

---
 rtl/gradient_batch_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/gradient_batch_arbiter.sv
// gradient_batch_arbiter: round-robin arbiter granting whole gradient batches from NUM_SRC streams to one adder input.
// Optional watchdog abort of stalled batches is enabled by defining GRAD_ARB_TIMEOUT_EN.
module gradient_batch_arbiter #(
    parameter int NUM_SRC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     s_TVALID,
    output logic [NUM_SRC-1:0]     s_TREADY,
    input  logic [NUM_SRC*512-1:0] s_TDATA,
    output logic                   m_TVALID,
    input  logic                   m_TREADY,
    output logic [511:0]           m_TDATA,
    output logic                   m_TLAST,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   batch_done,
    output logic                   timeout_err
);
    typedef enum logic [1:0] {ARB, HEADER, BODY} state_t;

    state_t      state, state_n;
    logic [2:0]  rr_ptr, rr_n, grant_n, pick, grant_inc;
    logic [27:0] remaining, rem_n;
    logic [28:0] lines;
    logic        hs, wd, done_n;

    assign busy        = state != ARB;
    assign hs          = m_TVALID & m_TREADY;
    assign lines       = 29'(({1'b0, m_TDATA[31:0]} + 33'd16) >> 4);
    assign grant_inc   = (grant_id == 3'(NUM_SRC - 1)) ? 3'd0 : grant_id + 3'd1;
    assign m_TLAST     = (state == HEADER && lines == 29'd1) || (state == BODY && remaining == 28'd1);
    assign timeout_err = wd;

    // Route the granted source through; everything is idle outside a batch.
    always_comb begin
        m_TVALID = 1'b0;
        m_TDATA  = '0;
        s_TREADY = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (busy && grant_id == 3'(i)) begin
                m_TVALID    = s_TVALID[i];
                m_TDATA     = s_TDATA[512*i +: 512];
                s_TREADY[i] = m_TREADY;
            end
        end
    end

    // First requester at or after rr_ptr, by smallest cyclic distance.
    always_comb begin
        int best, d;
        pick = rr_ptr;
        best = NUM_SRC;
        d    = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            d = i - int'(rr_ptr);
            if (d < 0) d = d + NUM_SRC;
            if (s_TVALID[i] && d < best) begin
                best = d;
                pick = 3'(i);
            end
        end
    end

`ifdef GRAD_ARB_TIMEOUT_EN
    logic [15:0] stall;

    // Count cycles since the last handshake of the current batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall <= '0;
        else if (state == ARB || hs) stall <= '0;
        else stall <= stall + 16'd1;
    end

    assign wd = busy && !hs && stall == 16'(TIMEOUT_CYC - 1);
`else
    assign wd = 1'b0;
`endif

    // Next-state: grant in ARB, size the batch from its header, count body lines down.
    always_comb begin
        state_n = state;
        grant_n = grant_id;
        rr_n    = rr_ptr;
        rem_n   = remaining;
        done_n  = 1'b0;
        case (state)
            ARB: begin
                if (|s_TVALID) begin
                    grant_n = pick;
                    state_n = HEADER;
                end
            end
            HEADER: begin
                if (wd) begin
                    state_n = ARB;
                    rr_n    = grant_inc;
                end else if (hs && lines == 29'd1) begin
                    state_n = ARB;
                    rr_n    = grant_inc;
                    done_n  = 1'b1;
                end else if (hs) begin
                    rem_n   = 28'(lines - 29'd1);
                    state_n = BODY;
                end
            end
            BODY: begin
                if (wd) begin
                    state_n = ARB;
                    rr_n    = grant_inc;
                end else if (hs && remaining == 28'd1) begin
                    state_n = ARB;
                    rr_n    = grant_inc;
                    done_n  = 1'b1;
                end else if (hs) begin
                    rem_n = remaining - 28'd1;
                end
            end
            default: state_n = ARB;
        endcase
    end

    // State and bookkeeping registers; reset aborts any batch silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            grant_id   <= '0;
            rr_ptr     <= '0;
            remaining  <= '0;
            batch_done <= 1'b0;
        end else begin
            state      <= state_n;
            grant_id   <= grant_n;
            rr_ptr     <= rr_n;
            remaining  <= rem_n;
            batch_done <= done_n;
        end
    end
endmodule
